// File: rtl/dbsm_frame_reader_if.sv
// ---------------------------------------------------------------------------
// dbsm_frame_reader_if
//   Bundles the three buses the double-buffer frame reader talks on:
//     - buffer-manager handshake : read_ok, read_ptr (to reader), read_done
//     - buffer RAM read port     : ram_en, ram_addr (from reader), ram_dat
//     - fifo36 output stream     : data_o, src_rdy_o (from reader), dst_rdy_i
//     - overrun                  : truncation pulse from the reader
//   modport master : the frame reader itself.
//   modport slave  : its environment (manager, RAM, downstream consumer).
// ---------------------------------------------------------------------------
interface dbsm_frame_reader_if #(
  parameter int AWIDTH = 9
);
  logic              read_ok;
  logic              read_ptr;
  logic              read_done;
  logic              ram_en;
  logic [AWIDTH:0]   ram_addr;
  logic [35:0]       ram_dat;
  logic [35:0]       data_o;
  logic              src_rdy_o;
  logic              dst_rdy_i;
  logic              overrun;

  modport master (
    input  read_ok, read_ptr, ram_dat, dst_rdy_i,
    output read_done, ram_en, ram_addr, data_o, src_rdy_o, overrun
  );

  modport slave (
    output read_ok, read_ptr, ram_dat, dst_rdy_i,
    input  read_done, ram_en, ram_addr, data_o, src_rdy_o, overrun
  );
endinterface

// File: rtl/dbsm_frame_reader.sv
// ---------------------------------------------------------------------------
// dbsm_frame_reader
//   Read-side engine of the double-buffer state machine. On a read grant it
//   streams one frame from the shared buffer RAM as a fifo36 stream
//   {occ[1:0], eof, sof, data[31:0]} and pulses read_done when the eof word
//   is accepted downstream.
//
//   Ports:
//     clk    : clock
//     reset  : synchronous, active-high reset
//     clear  : synchronous flush, same effect as reset
//     bus    : dbsm_frame_reader_if.master (manager handshake, RAM read port,
//              fifo36 output, overrun pulse)
//
//   Parameter AWIDTH : word-address width of one buffer (RAM address is
//                      AWIDTH+1 bits, {buffer index, offset}).
//
//   Build option DBSM_RD_OVERRUN_CHECK_EN: when defined, a word fetched from
//   the last offset of the buffer without eof is emitted with eof forced and
//   overrun pulses with its read_done. When undefined, the offset wraps and
//   overrun stays 0.
// ---------------------------------------------------------------------------
module dbsm_frame_reader #(
  parameter int AWIDTH = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  dbsm_frame_reader_if.master bus
);

  localparam logic [AWIDTH-1:0] OFS_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_buf_sel;
  logic [AWIDTH-1:0]   r_offset;
  logic                r_eof_fetched;
  logic                r_inflight;
  logic                r_done_hold;
  logic [1:0]          r_occ;
  // FIFO entries carry {overrun flag, fifo36 word}.
  logic [36:0]         r_f0;
  logic [36:0]         r_f1;
`ifdef DBSM_RD_OVERRUN_CHECK_EN
  logic                r_inflight_last;
`endif

  logic [36:0]         w_in;
  logic [36:0]         w_head;
  logic                w_arrive;
  logic                w_src_rdy;
  logic                w_pop;
  logic                w_pop_stored;
  logic                w_push;
  logic                w_done;
  logic [2:0]          w_level;
  logic                w_ram_en;

  // A returning word is only live while eof has not been fetched yet; the
  // single speculative fetch past eof lands with r_eof_fetched set and is
  // dropped here.
  assign w_arrive = r_inflight & ~r_eof_fetched;

`ifdef DBSM_RD_OVERRUN_CHECK_EN
  always_comb begin
    w_in = {1'b0, bus.ram_dat};
    if (r_inflight_last && !bus.ram_dat[33])
      w_in = {1'b1, bus.ram_dat[35:34], 1'b1, bus.ram_dat[32:0]};
  end
`else
  // Without the check nothing is ever flagged; the offset simply wraps.
  assign w_in = {1'b0, bus.ram_dat};
`endif

  // The word arriving from the RAM is presented directly when nothing is
  // stored, so a fetch issued in cycle k is visible in cycle k+1.
  assign w_src_rdy    = (r_occ != 2'd0) | w_arrive;
  assign w_head       = (r_occ != 2'd0) ? r_f0 : (w_arrive ? w_in : 37'd0);
  assign w_pop        = w_src_rdy & bus.dst_rdy_i;
  assign w_pop_stored = w_pop & (r_occ != 2'd0);
  assign w_push       = w_arrive & ~(w_pop & (r_occ == 2'd0));
  assign w_done       = w_pop & w_head[33];

  // Held plus in-flight words never exceed two: fetch only while
  // occ + inflight - pop < 2.
  assign w_level  = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_ram_en = (r_state == S_STREAM) & ~r_eof_fetched &
                    (w_pop ? (w_level < 3'd3) : (w_level < 3'd2));

  assign bus.ram_en    = w_ram_en;
  assign bus.ram_addr  = {r_buf_sel, r_offset};
  assign bus.data_o    = w_head[35:0];
  assign bus.src_rdy_o = w_src_rdy;
  assign bus.read_done = w_done;
  assign bus.overrun   = w_pop & w_head[36];

  // FIFO storage: data only, no reset needed since r_occ qualifies it.
  always_ff @(posedge clk) begin
    if (w_pop_stored) begin
      r_f0 <= (r_occ == 2'd2) ? r_f1 : w_in;
      if (r_occ == 2'd2)
        r_f1 <= w_in;
    end else if (w_push) begin
      if (r_occ == 2'd0)
        r_f0 <= w_in;
      else
        r_f1 <= w_in;
    end
  end

  // Control FSM and fetch engine.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state       <= S_IDLE;
      r_buf_sel     <= 1'b0;
      r_offset      <= '0;
      r_eof_fetched <= 1'b0;
      r_inflight    <= 1'b0;
      r_done_hold   <= 1'b0;
      r_occ         <= 2'd0;
`ifdef DBSM_RD_OVERRUN_CHECK_EN
      r_inflight_last <= 1'b0;
`endif
    end else begin
      r_inflight  <= w_ram_en;
      // Guarantees at least one idle cycle after read_done so the manager
      // can drop read_ok before it is sampled again.
      r_done_hold <= w_done;
      r_occ       <= r_occ + {1'b0, w_push} - {1'b0, w_pop_stored};
      if (w_ram_en)
        r_offset <= r_offset + OFS_ONE;
`ifdef DBSM_RD_OVERRUN_CHECK_EN
      r_inflight_last <= w_ram_en & (&r_offset);
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.read_ok && !r_done_hold) begin
            r_state       <= S_STREAM;
            r_buf_sel     <= bus.read_ptr;
            r_offset      <= '0;
            r_eof_fetched <= 1'b0;
          end
        end
        S_STREAM: begin
          if (w_arrive && w_in[33]) begin
            r_eof_fetched <= 1'b1;
            r_state       <= S_FLUSH;
          end
          if (w_done)
            r_state <= S_IDLE;
        end
        S_FLUSH: begin
          if (w_done)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbsm_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_dbsm_frame_reader
//   Directed bench for dbsm_frame_reader. u1/dut uses AWIDTH=9 for the
//   normal frame scenarios; u2/dut2 uses AWIDTH=2 for the buffer-end
//   behaviour (overrun truncation or wrap, depending on
//   DBSM_RD_OVERRUN_CHECK_EN). Cycle 0 of a scenario is the first cycle in
//   which read_ok is high; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dbsm_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic clear;
  logic clear2;

  dbsm_frame_reader_if #(.AWIDTH(9)) u1 ();
  dbsm_frame_reader_if #(.AWIDTH(2)) u2 ();

  dbsm_frame_reader #(.AWIDTH(9)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (u1)
  );

  dbsm_frame_reader #(.AWIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .clear (clear2),
    .bus   (u2)
  );

  logic [35:0] mem1 [0:1023];
  logic [35:0] mem2 [0:7];

  always @(posedge clk) if (u1.ram_en) u1.ram_dat <= mem1[u1.ram_addr];
  always @(posedge clk) if (u2.ram_en) u2.ram_dat <= mem2[u2.ram_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [9:0]  q_addr [$];
  logic [35:0] q_pop  [$];
  int          q_pcyc [$];
  int          q_done [$];
  bit          srdy_hist [0:63];

  function automatic logic [63:0] qa(input int i);
    if (i < q_addr.size()) return 64'(q_addr[i]);
    return '1;
  endfunction
  function automatic logic [63:0] qp(input int i);
    if (i < q_pop.size()) return 64'(q_pop[i]);
    return '1;
  endfunction
  function automatic logic [63:0] qpc(input int i);
    if (i < q_pcyc.size()) return 64'(q_pcyc[i]);
    return '1;
  endfunction
  function automatic logic [63:0] qd(input int i);
    if (i < q_done.size()) return 64'(q_done[i]);
    return '1;
  endfunction

  // Acts as buffer manager and consumer for dut: grants buffer p0 (then p1
  // if ngr==2) as soon as the previous read_done has been seen, and logs
  // fetch addresses, accepted words and read_done cycles.
  task automatic run_frames(input int ngr, input logic p0, input logic p1,
                            input int ncyc, input bit toggle, input int clr_cyc);
    int g;
    g = 0;
    q_addr.delete(); q_pop.delete(); q_pcyc.delete(); q_done.delete();
    for (int c = 0; c < ncyc; c++) begin
      u1.read_ptr = (g == 0) ? p0 : p1;
      u1.read_ok  = (g < ngr) && !(clr_cyc >= 0 && (c == clr_cyc || c == clr_cyc + 1));
      clear       = (c == clr_cyc);
      u1.dst_rdy_i = toggle ? (c % 2 == 0) : (c != clr_cyc);
      @(negedge clk);
      if (u1.ram_en) q_addr.push_back(u1.ram_addr);
      if (u1.src_rdy_o && u1.dst_rdy_i) begin
        q_pop.push_back(u1.data_o);
        q_pcyc.push_back(c);
      end
      if (u1.read_done) begin
        q_done.push_back(c);
        g++;
      end
      srdy_hist[c] = u1.src_rdy_o;
      @(posedge clk); #1;
    end
    u1.read_ok   = 1'b0;
    clear        = 1'b0;
    u1.dst_rdy_i = 1'b1;
  endtask

  logic [35:0] d2_data4, d2_data5;
  logic        d2_done4, d2_done5, d2_ovr4, d2_ovr5, d2_en5, d2_srdy6;
  logic [2:0]  d2_addr5;

  initial begin
    reset = 1'b1; clear = 1'b0; clear2 = 1'b0;
    u1.read_ok = 1'b0; u1.read_ptr = 1'b0; u1.dst_rdy_i = 1'b1; u1.ram_dat = '0;
    u2.read_ok = 1'b0; u2.read_ptr = 1'b0; u2.dst_rdy_i = 1'b1; u2.ram_dat = '0;
    for (int i = 0; i < 1024; i++) mem1[i] = '0;
    for (int i = 0; i < 8; i++) mem2[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_read_done", 64'(u1.read_done), 64'd0);
    check_eq("rst_ram_en",    64'(u1.ram_en),    64'd0);
    check_eq("rst_ram_addr",  64'(u1.ram_addr),  64'd0);
    check_eq("rst_data_o",    64'(u1.data_o),    64'd0);
    check_eq("rst_src_rdy",   64'(u1.src_rdy_o), 64'd0);
    check_eq("rst_overrun",   64'(u1.overrun),   64'd0);
    check_eq("rst2_data_o",   64'(u2.data_o),    64'd0);
    check_eq("rst2_overrun",  64'(u2.overrun),   64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: three-word frame, consumer always ready
    mem1[0] = 36'h1_AAAA0001; mem1[1] = 36'h0_AAAA0002; mem1[2] = 36'h2_AAAA0003;
    run_frames(1, 1'b0, 1'b0, 8, 1'b0, -1);
    check_eq("t1_naddr", 64'(q_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_eq("t1_addr", qa(i), 64'(i));
    check_eq("t1_npop", 64'(q_pop.size()), 64'd3);
    check_eq("t1_w0", qp(0), 64'h1_AAAA0001);
    check_eq("t1_w1", qp(1), 64'h0_AAAA0002);
    check_eq("t1_w2", qp(2), 64'h2_AAAA0003);
    check_eq("t1_w0_cyc", qpc(0), 64'd2);
    check_eq("t1_w2_cyc", qpc(2), 64'd4);
    check_eq("t1_ndone", 64'(q_done.size()), 64'd1);
    check_eq("t1_done_cyc", qd(0), 64'd4);
    check_eq("t1_srdy_c5", 64'(srdy_hist[5]), 64'd0);

    // 2: same frame, consumer ready on even cycles only
    run_frames(1, 1'b0, 1'b0, 10, 1'b1, -1);
    check_eq("t2_npop", 64'(q_pop.size()), 64'd3);
    check_eq("t2_w0", qp(0), 64'h1_AAAA0001);
    check_eq("t2_w1", qp(1), 64'h0_AAAA0002);
    check_eq("t2_w2", qp(2), 64'h2_AAAA0003);
    check_eq("t2_pop_cyc1", qpc(1), 64'd4);
    check_eq("t2_ndone", 64'(q_done.size()), 64'd1);
    check_eq("t2_done_cyc", qd(0), 64'd6);
    check_eq("t2_done_at_eof", qd(0), qpc(2));

    // 3: single-word frame in buffer 1
    mem1[10'h200] = 36'h3_12345678;
    run_frames(1, 1'b1, 1'b0, 6, 1'b0, -1);
    check_eq("t3_addr0", qa(0), 64'h200);
    check_eq("t3_naddr", 64'(q_addr.size()), 64'd2);
    check_eq("t3_npop", 64'(q_pop.size()), 64'd1);
    check_eq("t3_w0", qp(0), 64'h3_12345678);
    check_eq("t3_done_cyc", qd(0), 64'd2);
    check_eq("t3_srdy_c3", 64'(srdy_hist[3]), 64'd0);

    // 4: back-to-back grants, buffer 0 then buffer 1, two words each
    mem1[0] = 36'h1_B0000001; mem1[1] = 36'h2_B0000002;
    mem1[10'h200] = 36'h1_C0000001; mem1[10'h201] = 36'h2_C0000002;
    run_frames(2, 1'b0, 1'b1, 12, 1'b0, -1);
    check_eq("t4_naddr", 64'(q_addr.size()), 64'd6);
    check_eq("t4_addr0", qa(0), 64'h000);
    check_eq("t4_addr1", qa(1), 64'h001);
    check_eq("t4_addr3", qa(3), 64'h200);
    check_eq("t4_addr4", qa(4), 64'h201);
    check_eq("t4_npop", 64'(q_pop.size()), 64'd4);
    check_eq("t4_w1", qp(1), 64'h2_B0000002);
    check_eq("t4_w2", qp(2), 64'h1_C0000001);
    check_eq("t4_ndone", 64'(q_done.size()), 64'd2);
    check_eq("t4_done0", qd(0), 64'd3);
    check_eq("t4_done1", qd(1), 64'd8);

    // 5: clear after the second of five words, then a fresh grant
    mem1[0] = 36'h1_D0000001; mem1[1] = 36'h0_D0000002; mem1[2] = 36'h0_D0000003;
    mem1[3] = 36'h0_D0000004; mem1[4] = 36'h2_D0000005;
    run_frames(1, 1'b0, 1'b0, 16, 1'b0, 4);
    check_eq("t5_srdy_after_clr", 64'(srdy_hist[5]), 64'd0);
    check_eq("t5_restart_addr", qa(4), 64'h000);
    check_eq("t5_naddr", 64'(q_addr.size()), 64'd10);
    check_eq("t5_npop", 64'(q_pop.size()), 64'd7);
    check_eq("t5_pop2", qp(2), 64'h1_D0000001);
    check_eq("t5_pop6", qp(6), 64'h2_D0000005);
    check_eq("t5_ndone", 64'(q_done.size()), 64'd1);
    check_eq("t5_done_cyc", qd(0), 64'd12);

    // 6: AWIDTH=2 buffer filled with four words and no eof
    mem2[0] = 36'h1_E0000001; mem2[1] = 36'h0_E0000002;
    mem2[2] = 36'h0_E0000003; mem2[3] = 36'h0_E0000004;
    for (int c = 0; c < 7; c++) begin
      u2.read_ok = 1'b1;
      clear2 = (c == 6);
      @(negedge clk);
      if (c == 4) begin d2_data4 = u2.data_o; d2_done4 = u2.read_done; d2_ovr4 = u2.overrun; end
      if (c == 5) begin
        d2_data5 = u2.data_o; d2_done5 = u2.read_done; d2_ovr5 = u2.overrun;
        d2_en5 = u2.ram_en; d2_addr5 = u2.ram_addr;
      end
      if (c == 6) d2_srdy6 = u2.src_rdy_o;
      @(posedge clk); #1;
    end
    u2.read_ok = 1'b0; clear2 = 1'b0;
    check_eq("t6_data_c4", 64'(d2_data4), 64'h0_E0000003);
    check_eq("t6_done_c4", 64'(d2_done4), 64'd0);
    check_eq("t6_ovr_c4",  64'(d2_ovr4),  64'd0);
`ifdef DBSM_RD_OVERRUN_CHECK_EN
    check_eq("t6_data_c5", 64'(d2_data5), 64'h2_E0000004);
    check_eq("t6_done_c5", 64'(d2_done5), 64'd1);
    check_eq("t6_ovr_c5",  64'(d2_ovr5),  64'd1);
    check_eq("t6_srdy_c6", 64'(d2_srdy6), 64'd0);
`else
    check_eq("t6_data_c5", 64'(d2_data5), 64'h0_E0000004);
    check_eq("t6_done_c5", 64'(d2_done5), 64'd0);
    check_eq("t6_ovr_c5",  64'(d2_ovr5),  64'd0);
    check_eq("t6_wrap_en", 64'(d2_en5),   64'd1);
    check_eq("t6_wrap_addr", 64'(d2_addr5), 64'h0);
    check_eq("t6_srdy_c6", 64'(d2_srdy6), 64'd1);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
